// File: rtl/jt51_wrq_pkg.sv
// Shared types and constants for the JT51 register-write scheduler.
package jt51_wrq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_HOLD    = 3'd3,
    ST_WAIT    = 3'd4
  } wrq_state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wrq_pair_t;

  localparam logic       BUS_CS_N_OFF = 1'b1;
  localparam logic       BUS_WR_N_OFF = 1'b1;
  localparam logic       BUS_A0_OFF   = 1'b0;
  localparam logic [7:0] BUS_DIN_OFF  = 8'h00;

endpackage

// File: rtl/jt51_wrq_fifo.sv
// Synchronous DEPTH x 16 FIFO of {addr, data} pairs with flush.
module jt51_wrq_fifo
  import jt51_wrq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  wrq_pair_t                wdata,
  output wrq_pair_t                rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  wrq_pair_t     r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  // A push is refused while full even if a pop happens in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_level == (AW+1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign rdata = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush && !rst) r_mem[r_wp] <= wdata;
  end

endmodule

// File: rtl/jt51_wrq.sv
// Queues host register writes and replays them to the JT51 CPU port,
// waiting for the core busy flag between pairs.
module jt51_wrq
  import jt51_wrq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BUSY_HOLD = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen_p1,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [7:0]              req_addr,
  input  logic [7:0]              req_data,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    idle,
  output logic                    timeout_err,
  input  logic                    clr_err,
  output logic                    jt_cs_n,
  output logic                    jt_wr_n,
  output logic                    jt_a0,
  output logic [7:0]              jt_din,
  input  logic [7:0]              jt_dout
);

  localparam int HW = $clog2(BUSY_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  wrq_state_e    r_state;
  wrq_pair_t     r_pair;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_to;
  logic          r_err;
  logic          r_cs_n;
  logic          r_wr_n;
  logic          r_a0;
  logic [7:0]    r_din;

  wrq_pair_t     w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_busy;
  logic          w_unused;

  assign req_ready = !w_full && !flush;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_busy    = jt_dout[7];
  assign w_unused  = ^jt_dout[6:0];

  jt51_wrq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .wdata ('{addr: req_addr, data: req_data}),
    .rdata (w_head),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign idle        = w_empty && (r_state == ST_IDLE);
  assign timeout_err = r_err;
  assign jt_cs_n     = r_cs_n;
  assign jt_wr_n     = r_wr_n;
  assign jt_a0       = r_a0;
  assign jt_din      = r_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pair  <= '0;
      r_hold  <= '0;
      r_to    <= '0;
      r_err   <= 1'b0;
      r_cs_n  <= BUS_CS_N_OFF;
      r_wr_n  <= BUS_WR_N_OFF;
      r_a0    <= BUS_A0_OFF;
      r_din   <= BUS_DIN_OFF;
    end else begin
      if (clr_err) r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_pair  <= w_head;
            r_state <= ST_WR_ADDR;
          end
        end
        // The first WR_ADDR cycle only raises the strobes, so every visible
        // phase spans at least one clk before a cen_p1 tick can end it.
        ST_WR_ADDR: begin
          if (r_cs_n) begin
            r_cs_n <= 1'b0;
            r_wr_n <= 1'b0;
            r_a0   <= 1'b0;
            r_din  <= r_pair.addr;
          end else if (cen_p1) begin
            r_a0    <= 1'b1;
            r_din   <= r_pair.data;
            r_state <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (cen_p1) begin
            r_cs_n  <= BUS_CS_N_OFF;
            r_wr_n  <= BUS_WR_N_OFF;
            r_a0    <= BUS_A0_OFF;
            r_din   <= BUS_DIN_OFF;
            r_hold  <= HW'(BUSY_HOLD);
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cen_p1) begin
            r_hold <= r_hold - HW'(1);
            if (r_hold <= HW'(1)) begin
              r_to    <= '0;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!w_busy) begin
            r_state <= ST_IDLE;
          end else if (cen_p1) begin
            if (r_to == TW'(TIMEOUT - 1)) begin
              r_err   <= 1'b1;
              r_to    <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_to <= r_to + TW'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jt51_wrq.md
# jt51_wrq

Register-write scheduler for the JT51 core. It accepts (register address, data) pairs from any host-side requester through a valid/ready queue. It replays each pair onto the core's CPU port as an address write (a0=0) followed by a data write (a0=1), then holds off the next pair until the core's busy flag clears. Hosts never poll the busy bit themselves, and back-to-back register bursts (e.g. patch loads) cannot be lost.

## Interface
Parameters:
- DEPTH, 16, queue entries; power of two, ≥2
- BUSY_HOLD, 4, cen_p1 ticks after a data write before busy is sampled
- TIMEOUT, 1023, cen_p1 ticks allowed in busy-wait before forcing completion

Ports:
- clk  in  1  main clock, same as the JT51 core
- rst  in  1  reset; **synchronous and active-high, single clock domain (clk)**
- cen_p1  in  1  half-rate clock enable, same signal feeding the core
- req_valid  in  1  requester offers a write
- req_ready  out  1  queue can accept; equals !full && !flush
- req_addr  in  8  JT51 register address
- req_data  in  8  register data
- flush  in  1  discard all queued (not in-flight) entries
- level  out  $clog2(DEPTH)+1  queued entry count
- idle  out  1  queue empty and FSM in IDLE
- timeout_err  out  1  sticky: a busy-wait hit TIMEOUT
- clr_err  in  1  clears timeout_err
- jt_cs_n  out  1  to core cs_n
- jt_wr_n  out  1  to core wr_n
- jt_a0  out  1  to core a0
- jt_din  out  8  to core din
- jt_dout  in  8  from core dout; bit 7 = busy

## Operation
- Push: req_valid && req_ready at a clk edge stores {addr, data}. No push while full, even if a pop happens the same cycle.
- FSM states are IDLE, WR_ADDR, WR_DATA, HOLD and WAIT.
- IDLE → WR_ADDR when the queue is non-empty. The pop occurs on that transition; the head is latched into a holding register.
- WR_ADDR: cs_n=0, wr_n=0, a0=0, din=addr. Held until and including the first cycle with cen_p1=1; then → WR_DATA.
- WR_DATA: same strobes with a0=1, din=data. Held through the first cen_p1 cycle; then → HOLD with hold counter = BUSY_HOLD.
- HOLD: strobes inactive; counter decrements on cen_p1; → WAIT when the counter would reach 0.
- WAIT: timeout counter increments on cen_p1. → IDLE when jt_dout[7]==0. If the count reaches TIMEOUT: set timeout_err, → IDLE.
- Inactive bus values: cs_n=1, wr_n=1, a0=0, din=0.
- flush: queue pointers and level cleared at the next edge. An in-flight pair always completes. flush and clr_err have no effect on the FSM.
- clr_err and a simultaneous timeout: set wins.

## Timing
- Reset values: req_ready=1, level=0, idle=1, timeout_err=0, jt_cs_n=1, jt_wr_n=1, jt_a0=0, jt_din=0. All counters and pointers are 0. The FSM is in IDLE.
- Reset mid-transaction: strobes deassert on the next edge; the latched pair and the queue are dropped.
- Strobe outputs are registered. There is no combinational path from req_* to jt_*.
- Latency with an empty queue: push at edge N, IDLE sees non-empty at N+1, jt_cs_n falls after edge N+2.
- Each strobe phase lasts ≥1 clk and ends on the clk after the first cen_p1 high cycle inside it.
- Per-pair minimum throughput is 2 + BUSY_HOLD cen_p1 ticks plus busy time, plus 1 IDLE cycle.
- Pointer wrap is modulo DEPTH. level ranges 0..DEPTH. full = (level==DEPTH).
- Push and pop in the same cycle leave level unchanged.

## Structure
- Shared package jt51_wrq_pkg holds:
  - the FSM state localparams (3-bit encoding);
  - the inactive bus constants.
- Sub-module jt51_wrq_fifo: synchronous DEPTH×16 FIFO with push, pop, flush, level, full and empty.
- Top level holds the FSM, holding register, hold/timeout counters and error flag; roughly 250 lines total.

## Test plan
- Single write with cen_p1 toggling every clk: push (0x20, 0xC7). Expect:
  - an a0=0/din=0x20 strobe, then an a0=1/din=0xC7 strobe, each ending after a cen_p1 high cycle;
  - idle=1 after busy model drops.
- Burst of 20 pushes, DEPTH=16: req_ready=0 once level=16. All 20 pairs appear on jt_din in order, and no data strobe occurs while busy=1.
- Busy held high 5000 ticks, TIMEOUT=1023: timeout_err=1 after 1023 WAIT ticks, next pair proceeds, clr_err returns it to 0.
- flush asserted during WR_DATA of pair 1 with 5 queued: pair 1 completes, level=0 next edge, no further strobes.
- rst asserted in WR_ADDR: next edge jt_cs_n=1, jt_wr_n=1, level=0, idle=1; a fresh push after reset is issued normally.
- Stall cen_p1 low for 50 clk during WR_ADDR: strobe stays asserted with stable din for all 50 cycles, then advances.
